// File: rtl/ni_apb_master.sv
// Single-beat APB (v4) master for the NI request path. It issues one SETUP/ACCESS
// transfer per request and then holds the response until the NI response path takes it.
module ni_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                req_write_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  input  logic [DATA_W/8-1:0] req_strb_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_W-1:0]   resp_rdata_o,
  output logic                resp_err_o,
  output logic [ADDR_W-1:0]   paddr_o,
  output logic                psel_o,
  output logic                penable_o,
  output logic                pwrite_o,
  output logic [DATA_W-1:0]   pwdata_o,
  output logic [DATA_W/8-1:0] pstrb_o,
  input  logic [DATA_W-1:0]   prdata_i,
  input  logic                pready_i,
  input  logic                pslverr_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE_ST, SETUP_ST, ACCESS_ST, DONE_ST} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                psel_d, penable_d, pwrite_d, resp_valid_d, resp_err_d;
  logic [ADDR_W-1:0]   paddr_d;
  logic [DATA_W-1:0]   pwdata_d, resp_rdata_d;
  logic [STRB_W-1:0]   pstrb_d;
  logic                timeout_hit;

  assign req_ready_o = (state_q == IDLE_ST);

  // pready on the last allowed cycle takes priority over the timeout
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1)) && !pready_i;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    psel_d       = psel_o;
    penable_d    = penable_o;
    paddr_d      = paddr_o;
    pwrite_d     = pwrite_o;
    pwdata_d     = pwdata_o;
    pstrb_d      = pstrb_o;
    resp_valid_d = resp_valid_o;
    resp_rdata_d = resp_rdata_o;
    resp_err_d   = resp_err_o;
    case (state_q)
      IDLE_ST: begin
        if (req_valid_i) begin
          paddr_d   = req_addr_i;
          pwrite_d  = req_write_i;
          pwdata_d  = req_wdata_i;
          pstrb_d   = req_write_i ? req_strb_i : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = SETUP_ST;
        end
      end
      SETUP_ST: begin
        penable_d = 1'b1;
        state_d   = ACCESS_ST;
      end
      ACCESS_ST: begin
        if (pready_i) begin
          resp_rdata_d = (pwrite_o || pslverr_i) ? '0 : prdata_i;
          resp_err_d   = pslverr_i;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = DONE_ST;
        end else if (timeout_hit) begin
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = DONE_ST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE_ST: begin
        if (resp_ready_i) begin
          resp_valid_d = 1'b0;
          cnt_d        = '0;
          state_d      = IDLE_ST;
        end
      end
      default: state_d = IDLE_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE_ST;
      cnt_q        <= '0;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      paddr_o      <= '0;
      pwrite_o     <= 1'b0;
      pwdata_o     <= '0;
      pstrb_o      <= '0;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      psel_o       <= psel_d;
      penable_o    <= penable_d;
      paddr_o      <= paddr_d;
      pwrite_o     <= pwrite_d;
      pwdata_o     <= pwdata_d;
      pstrb_o      <= pstrb_d;
      resp_valid_o <= resp_valid_d;
      resp_rdata_o <= resp_rdata_d;
      resp_err_o   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_ni_apb_master.sv
// Self-checking bench for ni_apb_master: directed scenarios plus randomized
// transfers compared against a transaction-level model of latency and response.
module tb_ni_apb_master;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              resp_valid, resp_ready, resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] paddr;
  logic              psel, penable, pwrite;
  logic [DATA_W-1:0] pwdata, prdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready, pslverr;

  int tests_run    = 0;
  int tests_failed = 0;

  ni_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level expectation: waits = pready-low cycles before completion
  function automatic void model(input logic wr, input int waits, input logic slverr,
                                input logic [DATA_W-1:0] rd, output int exp_lat,
                                output logic [DATA_W-1:0] exp_rdata, output logic exp_err);
    if (TIMEOUT != 0 && waits >= TIMEOUT) begin
      exp_lat   = 2 + TIMEOUT;
      exp_rdata = '0;
      exp_err   = 1'b1;
    end else begin
      exp_lat   = 2 + waits + 1;
      exp_rdata = (wr || slverr) ? '0 : rd;
      exp_err   = slverr;
    end
  endfunction

  // Drives one transfer and reports what it observed; protocol slips count in viol
  task automatic run_txn(input logic [ADDR_W-1:0] addr, input logic wr,
                         input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb,
                         input int waits, input logic slverr, input logic [DATA_W-1:0] rd,
                         input int delay, output int lat, output int rdy,
                         output logic [DATA_W-1:0] rdata, output logic err, output int viol);
    int cyc;
    int acc;
    logic [STRB_W-1:0] exp_strb;
    exp_strb = wr ? strb : '0;
    viol = 0; lat = -1; rdy = -1; rdata = '0; err = 1'b0;
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata; req_strb = strb;
    if (req_ready !== 1'b1) viol++;
    tick(); cyc = 1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_strb = 4'hF;
    if (psel !== 1'b1 || penable !== 1'b0) viol++;
    if (paddr !== addr || pwrite !== wr || pwdata !== wdata || pstrb !== exp_strb) viol++;
    acc = 0;
    while (cyc < 100) begin
      tick(); cyc++;
      pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      if (resp_valid === 1'b1) begin
        lat = cyc;
        break;
      end
      if (psel !== 1'b1 || penable !== 1'b1 || req_ready !== 1'b0) viol++;
      if (paddr !== addr || pwrite !== wr || pwdata !== wdata || pstrb !== exp_strb) viol++;
      if (acc == waits) begin
        pready = 1'b1; pslverr = slverr; prdata = rd;
      end
      acc++;
    end
    if (lat >= 0) begin
      rdata = resp_rdata;
      err   = resp_err;
      if (psel !== 1'b0 || penable !== 1'b0) viol++;
      req_valid = 1'b1; req_write = 1'b1;
      for (int i = 0; i < delay; i++) begin
        if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
            req_ready !== 1'b0 || psel !== 1'b0) viol++;
        tick(); cyc++;
      end
      if (resp_valid !== 1'b1 || resp_rdata !== rdata || resp_err !== err ||
          req_ready !== 1'b0 || psel !== 1'b0) viol++;
      resp_ready = 1'b1;
      tick(); cyc++;
      resp_ready = 1'b0; req_valid = 1'b0;
      if (req_ready === 1'b1 && resp_valid === 1'b0) rdy = cyc;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready);
    end
    tests_run++;
    if ({psel, penable, pwrite, resp_valid, resp_err} !== 5'b0) begin
      tests_failed++; $display("[TB] FAIL reset_ctrl: got %b want 00000", {psel, penable, pwrite, resp_valid, resp_err});
    end
    tests_run++;
    if (paddr !== '0 || pwdata !== '0 || pstrb !== '0 || resp_rdata !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_data: got %h/%h/%h/%h want 0", paddr, pwdata, pstrb, resp_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Shared comparison block is written out per test to keep each scenario self-contained
  task automatic test_read_zero_wait();
    int lat, rdy, viol;
    logic [DATA_W-1:0] rdata;
    logic err;
    run_txn(32'h40, 1'b0, 32'h0, 4'hF, 0, 1'b0, 32'hDEADBEEF, 0, lat, rdy, rdata, err, viol);
    tests_run++;
    if (lat !== 3 || rdy !== 4) begin
      tests_failed++; $display("[TB] FAIL read0_latency: got resp %0d ready %0d want 3 4", lat, rdy);
    end
    tests_run++;
    if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL read0_resp: got %h err %b want deadbeef err 0", rdata, err);
    end
    tests_run++;
    if (viol !== 0) begin
      tests_failed++; $display("[TB] FAIL read0_protocol: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_write_wait();
    int lat, rdy, viol;
    logic [DATA_W-1:0] rdata;
    logic err;
    run_txn(32'h10, 1'b1, 32'h12345678, 4'hF, 3, 1'b0, 32'hA5A5A5A5, 0, lat, rdy, rdata, err, viol);
    tests_run++;
    if (lat !== 6 || rdy !== 7) begin
      tests_failed++; $display("[TB] FAIL write3_latency: got resp %0d ready %0d want 6 7", lat, rdy);
    end
    tests_run++;
    if (rdata !== '0 || err !== 1'b0 || viol !== 0) begin
      tests_failed++; $display("[TB] FAIL write3_resp: got %h err %b viol %0d want 0 0 0", rdata, err, viol);
    end
  endtask

  task automatic test_slave_error();
    int lat, rdy, viol;
    logic [DATA_W-1:0] rdata;
    logic err;
    run_txn(32'h80, 1'b0, 32'h0, 4'h3, 1, 1'b1, 32'hFFFFFFFF, 0, lat, rdy, rdata, err, viol);
    tests_run++;
    if (rdata !== '0 || err !== 1'b1 || lat !== 4 || viol !== 0) begin
      tests_failed++; $display("[TB] FAIL slverr: got %h err %b lat %0d viol %0d want 0 1 4 0", rdata, err, lat, viol);
    end
  endtask

  task automatic test_timeout();
    int lat, rdy, viol;
    logic [DATA_W-1:0] rdata;
    logic err;
    run_txn(32'h24, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 32'h11111111, 0, lat, rdy, rdata, err, viol);
    tests_run++;
    if (lat !== 2 + TIMEOUT || rdata !== '0 || err !== 1'b1 || viol !== 0) begin
      tests_failed++; $display("[TB] FAIL timeout: got lat %0d %h err %b viol %0d want %0d 0 1 0", lat, rdata, err, viol, 2 + TIMEOUT);
    end
    run_txn(32'h28, 1'b0, 32'h0, 4'h0, TIMEOUT - 1, 1'b0, 32'h22222222, 0, lat, rdy, rdata, err, viol);
    tests_run++;
    if (lat !== 2 + TIMEOUT || rdata !== 32'h22222222 || err !== 1'b0 || viol !== 0) begin
      tests_failed++; $display("[TB] FAIL timeout_last_ready: got lat %0d %h err %b viol %0d want %0d 22222222 0 0", lat, rdata, err, viol, 2 + TIMEOUT);
    end
  endtask

  task automatic test_backpressure();
    int lat, rdy, viol;
    logic [DATA_W-1:0] rdata;
    logic err;
    run_txn(32'h44, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'hCAFEF00D, 5, lat, rdy, rdata, err, viol);
    tests_run++;
    if (lat !== 3 || rdy !== 9 || viol !== 0) begin
      tests_failed++; $display("[TB] FAIL backpressure: got resp %0d ready %0d viol %0d want 3 9 0", lat, rdy, viol);
    end
    tests_run++;
    if (rdata !== 32'hCAFEF00D || err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL backpressure_resp: got %h err %b want cafef00d 0", rdata, err);
    end
  endtask

  task automatic test_reset_mid_access();
    int seen_resp;
    req_valid = 1'b1; req_addr = 32'h5C; req_write = 1'b1; req_wdata = 32'h0BADCAFE; req_strb = 4'h6;
    tick();
    req_valid = 1'b0;
    tick();
    tests_run++;
    if (penable !== 1'b1 || psel !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midreset_access: got psel %b penable %b want 1 1", psel, penable);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests_run++;
    if ({psel, penable, pwrite, resp_valid, resp_err} !== 5'b0 || paddr !== '0 ||
        pwdata !== '0 || pstrb !== '0 || resp_rdata !== '0 || req_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midreset_outputs: got ctrl %b addr %h data %h strb %h ready %b want 0 0 0 0 1",
                               {psel, penable, pwrite, resp_valid, resp_err}, paddr, pwdata, pstrb, req_ready);
    end
    pready = 1'b1;
    seen_resp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid !== 1'b0 || psel !== 1'b0) seen_resp++;
    end
    pready = 1'b0;
    tests_run++;
    if (seen_resp !== 0) begin
      tests_failed++; $display("[TB] FAIL midreset_no_resp: got %0d active cycles want 0", seen_resp);
    end
  endtask

  task automatic test_random();
    int lat, rdy, viol, exp_lat, waits, delay;
    logic [DATA_W-1:0] rdata, exp_rdata, rd;
    logic err, exp_err, wr, slverr;
    for (int n = 0; n < 25; n++) begin
      wr     = 1'($urandom);
      slverr = ($urandom_range(0, 3) == 0);
      waits  = $urandom_range(0, 20);
      delay  = $urandom_range(0, 3);
      rd     = $urandom;
      model(wr, waits, slverr, rd, exp_lat, exp_rdata, exp_err);
      run_txn($urandom, wr, $urandom, 4'($urandom), waits, slverr, rd, delay,
              lat, rdy, rdata, err, viol);
      tests_run++;
      if (lat !== exp_lat || rdy !== exp_lat + delay + 1) begin
        tests_failed++; $display("[TB] FAIL rand%0d_timing: got resp %0d ready %0d want %0d %0d", n, lat, rdy, exp_lat, exp_lat + delay + 1);
      end
      tests_run++;
      if (rdata !== exp_rdata || err !== exp_err || viol !== 0) begin
        tests_failed++; $display("[TB] FAIL rand%0d_resp: got %h err %b viol %0d want %h err %b viol 0", n, rdata, err, viol, exp_rdata, exp_err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_strb = '0; resp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_slave_error();
    test_timeout();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/ni_apb_master.md
Name: ni_apb_master

Overview:
- Bridges single-beat register requests from the network-interface request path onto an AMBA APB (v4) bus.
- Sits directly downstream of the NI request FSM and drives one APB completer.
- Returns read data and error status to the NI response path over a valid/ready channel.
- State machine uses the shared four-state APB master encoding: IDLE_ST, SETUP_ST, ACCESS_ST, DONE_ST.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width (multiple of 8)
TIMEOUT, 16, max ACCESS_ST cycles waiting for pready; 0 disables timeout

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid_i  input  1  NI request valid
req_ready_o  output  1  block can accept request
req_addr_i  input  ADDR_W  request address
req_write_i  input  1  1=write, 0=read
req_wdata_i  input  DATA_W  write data
req_strb_i  input  DATA_W/8  write byte strobes
resp_valid_o  output  1  response valid
resp_ready_i  input  1  NI response path accepts
resp_rdata_o  output  DATA_W  read data (0 for writes/errors)
resp_err_o  output  1  pslverr or timeout
paddr_o  output  ADDR_W  APB address
psel_o  output  1  APB select
penable_o  output  1  APB enable
pwrite_o  output  1  APB direction
pwdata_o  output  DATA_W  APB write data
pstrb_o  output  DATA_W/8  APB strobes (forced 0 on reads)
prdata_i  input  DATA_W  APB read data
pready_i  input  1  APB ready
pslverr_i  input  1  APB slave error

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE_ST, timeout counter=0. All registered outputs 0: psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o, resp_valid_o, resp_rdata_o, resp_err_o. Applies mid-transfer: the APB transfer is abandoned and no response is issued.
- req_ready_o = (state==IDLE_ST), combinational from state; rst_n=0 in the current cycle does not mask it.
- IDLE_ST:
  - On req_valid_i & req_ready_o, capture addr/write/wdata/strb into paddr_o/pwrite_o/pwdata_o/pstrb_o; pstrb_o=0 if read.
  - Next state SETUP_ST, psel_o=1, penable_o=0.
- SETUP_ST: exactly one cycle. Next state ACCESS_ST, penable_o=1.
- ACCESS_ST:
  - paddr/pwrite/pwdata/pstrb held stable. Counter increments each cycle pready_i=0.
  - On pready_i=1: resp_rdata_o = pwrite ? 0 : (pslverr_i ? 0 : prdata_i); resp_err_o = pslverr_i; psel_o=0, penable_o=0, resp_valid_o=1, next DONE_ST.
  - Timeout (TIMEOUT!=0, counter==TIMEOUT-1, pready_i=0): psel_o=0, penable_o=0, resp_rdata_o=0, resp_err_o=1, resp_valid_o=1, next DONE_ST.
  - pready_i=1 on the timeout cycle wins as a normal completion.
- DONE_ST:
  - resp_valid_o and response data held stable until resp_ready_i=1.
  - On handshake: resp_valid_o=0, counter=0, next IDLE_ST. No new request is accepted in DONE_ST.
- Counter width: $clog2(TIMEOUT+1), minimum 1. Cleared on entry to SETUP_ST.
- APB address/data/strb/pwrite outputs retain their last values in IDLE_ST/DONE_ST with psel_o=0.
- Latency, zero wait states:
  - Request accepted at cycle 0; SETUP cycle 1; ACCESS cycle 2 with pready; resp_valid_o high cycle 3.
  - With resp_ready_i=1, req_ready_o high again cycle 4. Throughput 1 transfer per 4 cycles minimum.
- Protocol invariants: penable_o=1 implies psel_o=1. psel_o never deasserts between SETUP and pready/timeout.

Test Plan:
- Read, zero wait: req addr=0x40 write=0, prdata=0xDEADBEEF, pready=1 in first ACCESS cycle -> psel cycles 1-2, penable cycle 2, resp_valid cycle 3 with rdata=0xDEADBEEF, err=0, req_ready cycle 4.
- Write with 3 wait states: addr=0x10 wdata=0x12345678 strb=0xF, pready after 3 low cycles -> paddr/pwdata/pstrb stable throughout ACCESS, resp_valid 3 cycles later than zero-wait, rdata=0, err=0.
- Slave error: read, pready=1 & pslverr=1, prdata=0xFFFFFFFF -> resp_err=1, rdata=0.
- Timeout: TIMEOUT=16, pready held 0 -> psel/penable drop after 16 ACCESS cycles, resp_valid=1, err=1, rdata=0. Repeat with pready=1 on the 16th cycle -> normal completion, err=0.
- Response backpressure: resp_ready=0 for 5 cycles in DONE_ST -> resp_valid/rdata/err stable, req_ready=0, a pending req_valid is not accepted until 1 cycle after the handshake.
- Reset mid-ACCESS: rst_n=0 for one cycle while penable=1 -> next cycle all outputs 0, state IDLE, req_ready=1, no response issued.
